reg_bank_inc: RTL
=================

REG_BANK_INC -- requirements
Module: reg_bank_inc

Interface
REQ-001 Parameter WIDTH, default 16: data width of each channel register and bus lane.
REQ-002 Parameter NCH, default 4: number of independent register channels, one per core.
REQ-003 Parameter STEP, default 1: unsigned increment/decrement amount, WIDTH bits.
REQ-004 Parameter SAT, default 0: 0 = wrap-around arithmetic, 1 = saturating arithmetic.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 RST_N  input  1  asynchronous active-low reset for the whole bank.
REQ-007 CLR  input  NCH  per-channel synchronous clear (bit i clears channel i).
REQ-008 WR  input  NCH  per-channel write from the bus.
REQ-009 INC  input  NCH  per-channel increment by STEP.
REQ-010 DEC  input  NCH  per-channel decrement by STEP.
REQ-011 LDBUS  input  NCH  per-channel request to drive the register onto the output lane.
REQ-012 BIN  input  NCH*WIDTH  write data; lane i is bits [i*WIDTH +: WIDTH].
REQ-013 BOUT  output  NCH*WIDTH  registered output lanes, same lane mapping as BIN.
REQ-014 BVALID  output  NCH  one-cycle pulse: lane i of BOUT was updated this cycle.
REQ-015 OVF  output  NCH  sticky flag: channel i wrapped or saturated since its last clear.

Function
REQ-016 Each channel SHALL hold a WIDTH-bit unsigned register, fully independent of the other channels.
REQ-017 Per-channel update priority at each rising edge SHALL be CLR > WR > INC > DEC > hold.
REQ-018 CLR: register <= 0, OVF <= 0.
REQ-019 WR: register <= BIN lane; OVF unchanged.
REQ-020 INC with SAT=0: register <= (register + STEP) mod 2^WIDTH; OVF <= 1 if the carry-out is set.
REQ-021 INC with SAT=1: register <= min(register + STEP, 2^WIDTH-1); OVF <= 1 if clamping occurred.
REQ-022 DEC with SAT=0: register <= (register - STEP) mod 2^WIDTH; OVF <= 1 on borrow.
REQ-023 DEC with SAT=1: register <= max(register - STEP, 0); OVF <= 1 if clamping occurred.
REQ-024 INC and DEC asserted together, with CLR and WR low: INC SHALL win, per REQ-017.
REQ-025 OVF SHALL remain set until that channel's CLR or RST_N; it SHALL NOT clear on WR.
REQ-026 LDBUS high at an edge: BOUT lane <= register value before that edge's update, and BVALID bit = 1 for exactly that cycle.
REQ-027 LDBUS low: BOUT lane SHALL hold its last value and BVALID bit SHALL be 0.
REQ-028 LDBUS with a simultaneous update SHALL output the old value; the new value appears on the next LDBUS.
REQ-029 Latency: a register update is visible via LDBUS one edge after it is applied.
REQ-030 With STEP = 0, INC and DEC SHALL leave the register unchanged and SHALL NOT set OVF.

Reset
REQ-031 RST_N low SHALL immediately, without waiting for a clock edge, force all registers, BOUT, BVALID and OVF to 0.
REQ-032 While RST_N is low, all control inputs SHALL be ignored.
REQ-033 The first rising edge after RST_N deasserts SHALL process inputs normally.
REQ-034 Reset asserted mid-operation SHALL discard any pending update and any BVALID pulse.

Verification
REQ-035 WIDTH=16, SAT=0: WR ch0 0xFFFF; INC ch0 -> register 0x0000, OVF[0]=1; LDBUS ch0 -> BOUT lane0 0x0000, BVALID[0] pulse.
REQ-036 SAT=1, STEP=4: WR ch1 0x0002; DEC ch1 -> register 0x0000, OVF[1]=1; CLR ch1 -> OVF[1]=0.
REQ-037 Same edge: CLR, WR=0x1234, INC and LDBUS on ch2, register holding 0x0007 -> BOUT lane2 0x0007, register 0x0000.
REQ-038 Channel isolation: INC ch3 for 10 cycles while ch0-ch2 hold 0xAAAA -> ch3 = 10, other channels unchanged.
REQ-039 Drop RST_N between clock edges while registers are non-zero -> all outputs 0 before the next edge; WR is ignored until deassertion.
REQ-040 WR ch0 0x00FF, then INC and DEC together -> register 0x0100, no OVF.

Source files
------------

// File: rtl/reg_bank_inc.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_inc
// Description : Bank of NCH independent WIDTH-bit registers. Each channel has
//               its own clear, write, increment and decrement controls, which
//               are resolved in that order of precedence. Arithmetic either
//               wraps or saturates. A sticky overflow flag records any wrap or
//               clamp. A registered readout lane returns the pre-update value
//               together with a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_inc #(
    parameter int unsigned      WIDTH = 16,
    parameter int unsigned      NCH   = 4,
    parameter logic [WIDTH-1:0] STEP  = WIDTH'(1),
    parameter bit               SAT   = 1'b0
) (
    input  logic                   clk,
    input  logic                   RST_N,
    input  logic [NCH-1:0]         CLR,
    input  logic [NCH-1:0]         WR,
    input  logic [NCH-1:0]         INC,
    input  logic [NCH-1:0]         DEC,
    input  logic [NCH-1:0]         LDBUS,
    input  logic [NCH*WIDTH-1:0]   BIN,
    output logic [NCH*WIDTH-1:0]   BOUT,
    output logic [NCH-1:0]         BVALID,
    output logic [NCH-1:0]         OVF
);

    localparam logic [WIDTH-1:0] c_max  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_zero = '0;

    // Packed so that element i lines up with lane i of BIN/BOUT.
    logic [NCH-1:0][WIDTH-1:0] r_reg;
    logic [NCH-1:0][WIDTH-1:0] r_bout;
    logic [NCH-1:0]            r_bvalid;
    logic [NCH-1:0]            r_ovf;

    // Extra top bit carries the carry-out (sum) or borrow (difference).
    logic [NCH-1:0][WIDTH:0]   w_sum;
    logic [NCH-1:0][WIDTH:0]   w_diff;

    // Per-channel step arithmetic, widened by one bit to expose carry/borrow.
    always_comb begin
        w_sum  = '0;
        w_diff = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sum[i]  = {1'b0, r_reg[i]} + {1'b0, STEP};
            w_diff[i] = {1'b0, r_reg[i]} - {1'b0, STEP};
        end
    end

    // Channel state update and readout capture; readout samples the value held before this edge.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_reg    <= '0;
            r_bout   <= '0;
            r_bvalid <= '0;
            r_ovf    <= '0;
        end else begin
            r_bvalid <= LDBUS;
            for (int i = 0; i < NCH; i++) begin
                if (LDBUS[i]) begin
                    r_bout[i] <= r_reg[i];
                end

                if (CLR[i]) begin
                    r_reg[i] <= c_zero;
                    r_ovf[i] <= 1'b0;
                end else if (WR[i]) begin
                    r_reg[i] <= BIN[i*WIDTH +: WIDTH];
                end else if (INC[i]) begin
                    if (w_sum[i][WIDTH]) begin
                        r_reg[i] <= SAT ? c_max : w_sum[i][WIDTH-1:0];
                        r_ovf[i] <= 1'b1;
                    end else begin
                        r_reg[i] <= w_sum[i][WIDTH-1:0];
                    end
                end else if (DEC[i]) begin
                    if (w_diff[i][WIDTH]) begin
                        r_reg[i] <= SAT ? c_zero : w_diff[i][WIDTH-1:0];
                        r_ovf[i] <= 1'b1;
                    end else begin
                        r_reg[i] <= w_diff[i][WIDTH-1:0];
                    end
                end
            end
        end
    end

    assign BOUT   = r_bout;
    assign BVALID = r_bvalid;
    assign OVF    = r_ovf;

endmodule
`default_nettype wire
